// File: rtl/reg_share_arbiter_if.sv
// Requester-side bundle for the shared-register arbiter: four requests with data in,
// one-hot grant/ack plus shared register contents, owner and busy out.
interface reg_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   Q;
    logic [1:0]         owner;
    logic               busy;

    modport master (
        output req, req_data,
        input  gnt, ack, Q, owner, busy
    );

    modport slave (
        input  req, req_data,
        output gnt, ack, Q, owner, busy
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and sole writer of a shared WIDTH-bit register: gnt one cycle after a request,
// Q/ack the cycle after that, then HOLD_CYC cycles during which requests are ignored (not queued).
module reg_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       win_q, win_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       hold_q, hold_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       ack_q, ack_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;

    logic [7:0]       req_dbl;
    logic [3:0]       req_rot;
    logic [1:0]       rot_idx;
    logic [1:0]       pick;

    // Rotate requests so bit 0 is the requester just after the last writer,
    // then the lowest set bit is the round-robin winner.
    always_comb begin
        req_dbl = {bus.req, bus.req};
        req_rot = req_dbl[3'(last_q) + 3'd1 +: 4];
        casez (req_rot)
            4'b???1: rot_idx = 2'd0;
            4'b??10: rot_idx = 2'd1;
            4'b?100: rot_idx = 2'd2;
            default: rot_idx = 2'd3;
        endcase
        pick = last_q + 2'd1 + rot_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            win_q   <= 2'd0;
            owner_q <= 2'd0;
            hold_q  <= 4'd0;
            gnt_q   <= 4'd0;
            ack_q   <= 4'd0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|bus.req) state_d = ST_GRANT;
            ST_GRANT: state_d = bus.req[win_q] ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (hold_q == 4'd0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A requester that drops req during GRANT aborts: no write, pointer untouched.
    always_comb begin
        win_d   = win_q;
        last_d  = last_q;
        owner_d = owner_q;
        q_d     = q_q;
        hold_d  = hold_q;
        gnt_d   = 4'd0;
        ack_d   = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    win_d = pick;
                    gnt_d = 4'd1 << pick;
                end
            end
            ST_GRANT: begin
                if (bus.req[win_q]) begin
                    q_d     = bus.req_data[win_q*WIDTH +: WIDTH];
                    ack_d   = 4'd1 << win_q;
                    owner_d = win_q;
                    last_d  = win_q;
                    hold_d  = 4'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (hold_q != 4'd0) hold_d = hold_q - 4'd1;
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.Q     = q_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Drives three arbiters (HOLD_CYC 2, 1, 15) from one request stream and checks each every cycle
// against a phase-timeline model, plus literal expectations for the documented scenarios.
module tb_reg_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_s;
    logic [31:0] data_s;

    int n_checks = 0;
    int n_fail   = 0;

    reg_share_arbiter_if #(.WIDTH(8)) if0 ();
    reg_share_arbiter_if #(.WIDTH(8)) if1 ();
    reg_share_arbiter_if #(.WIDTH(8)) if2 ();

    assign if0.req = req_s;  assign if0.req_data = data_s;
    assign if1.req = req_s;  assign if1.req_data = data_s;
    assign if2.req = req_s;  assign if2.req_data = data_s;

    reg_share_arbiter #(.WIDTH(8), .HOLD_CYC(2))  dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    reg_share_arbiter #(.WIDTH(8), .HOLD_CYC(1))  dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    reg_share_arbiter #(.WIDTH(8), .HOLD_CYC(15)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    logic [3:0] d_gnt [3];
    logic [3:0] d_ack [3];
    logic [7:0] d_q   [3];
    logic [1:0] d_own [3];
    logic       d_bsy [3];

    assign d_gnt[0] = if0.gnt;  assign d_ack[0] = if0.ack;  assign d_q[0] = if0.Q;
    assign d_own[0] = if0.owner; assign d_bsy[0] = if0.busy;
    assign d_gnt[1] = if1.gnt;  assign d_ack[1] = if1.ack;  assign d_q[1] = if1.Q;
    assign d_own[1] = if1.owner; assign d_bsy[1] = if1.busy;
    assign d_gnt[2] = if2.gnt;  assign d_ack[2] = if2.ack;  assign d_q[2] = if2.Q;
    assign d_own[2] = if2.owner; assign d_bsy[2] = if2.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = free, 1 = granted, 2..1+H = holding after a write.
    int         hold_of [3] = '{2, 1, 15};
    int         phase   [3];
    int         m_win   [3];
    int         m_last  [3];
    int         m_owner [3];
    logic [7:0] m_q     [3];
    logic       m_ack   [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                phase[k] = 0; m_win[k] = 0; m_last[k] = 3;
                m_owner[k] = 0; m_q[k] = 8'h00; m_ack[k] = 1'b0;
            end else begin
                m_ack[k] = 1'b0;
                if (phase[k] == 0) begin
                    if (req_s != 4'd0) begin
                        for (int s = 4; s >= 1; s--)
                            if (req_s[(m_last[k] + s) % 4]) m_win[k] = (m_last[k] + s) % 4;
                        phase[k] = 1;
                    end
                end else if (phase[k] == 1) begin
                    if (req_s[m_win[k]]) begin
                        m_q[k]     = data_s[m_win[k]*8 +: 8];
                        m_owner[k] = m_win[k];
                        m_last[k]  = m_win[k];
                        m_ack[k]   = 1'b1;
                        phase[k]   = 2;
                    end else begin
                        phase[k] = 0;
                    end
                end else if (phase[k] == 1 + hold_of[k]) begin
                    phase[k] = 0;
                end else begin
                    phase[k] = phase[k] + 1;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gnt%0d", k), 32'(d_gnt[k]), (phase[k] == 1) ? (32'd1 << m_win[k]) : 32'd0);
            chk($sformatf("ack%0d", k), 32'(d_ack[k]), m_ack[k] ? (32'd1 << m_owner[k]) : 32'd0);
            chk($sformatf("q%0d", k),   32'(d_q[k]),   32'(m_q[k]));
            chk($sformatf("own%0d", k), 32'(d_own[k]), 32'(m_owner[k]));
            chk($sformatf("bsy%0d", k), 32'(d_bsy[k]), (phase[k] != 0) ? 32'd1 : 32'd0);
        end
    end

    int         ack_cnt [3];
    int         ack_cyc [3][5];
    logic [7:0] ack_val [3][5];
    logic [7:0] rr_exp  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        rst = 1'b1; req_s = 4'd0; data_s = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(d_gnt[0]), 32'd0);
        chk("rst_busy", 32'(d_bsy[0]), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single write of 0xA5 from requester 1
        data_s = 32'h0000_A500; req_s = 4'b0010;
        @(negedge clk); chk("sw_gnt", 32'(d_gnt[0]), 32'b0010);
        @(negedge clk);
        chk("sw_q", 32'(d_q[0]), 32'hA5);
        chk("sw_ack", 32'(d_ack[0]), 32'b0010);
        chk("sw_owner", 32'(d_own[0]), 32'd1);
        req_s = 4'd0;
        @(negedge clk); chk("sw_ack_clr", 32'(d_ack[0]), 32'd0);
        @(negedge clk); chk("sw_busy_clr", 32'(d_bsy[0]), 32'd0);
        repeat (20) @(negedge clk);

        // abort: requester 2 drops during GRANT, pointer must stay on requester 1
        data_s = 32'h005A_0077; req_s = 4'b0100;
        @(negedge clk); chk("ab_gnt", 32'(d_gnt[0]), 32'b0100);
        req_s = 4'd0;
        @(negedge clk);
        chk("ab_busy", 32'(d_bsy[0]), 32'd0);
        chk("ab_ack", 32'(d_ack[0]), 32'd0);
        chk("ab_q", 32'(d_q[0]), 32'hA5);
        req_s = 4'b0101;
        @(negedge clk); chk("ab_ptr", 32'(d_gnt[0]), 32'b0100);
        @(negedge clk);
        chk("ab_q2", 32'(d_q[0]), 32'h5A);
        chk("ab_owner2", 32'(d_own[0]), 32'd2);
        req_s = 4'd0;
        repeat (20) @(negedge clk);

        // async reset while requester 1 holds the grant
        data_s = 32'h0000_3C00; req_s = 4'b0010;
        @(negedge clk); chk("mg_gnt", 32'(d_gnt[0]), 32'b0010);
        #2 rst = 1'b1;
        #1;
        chk("mg_gnt0", 32'(d_gnt[0]), 32'd0);
        chk("mg_ack0", 32'(d_ack[0]), 32'd0);
        chk("mg_q0", 32'(d_q[0]), 32'd0);
        chk("mg_owner0", 32'(d_own[0]), 32'd0);
        chk("mg_busy0", 32'(d_bsy[0]), 32'd0);
        data_s = 32'h4433_2211; req_s = 4'b1111;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); chk("mg_first", 32'(d_gnt[0]), 32'b0001);

        // continuous requests: record the first five writes of each build
        for (int k = 0; k < 3; k++) begin
            ack_cnt[k] = 0;
            for (int i = 0; i < 5; i++) begin ack_cyc[k][i] = 0; ack_val[k][i] = 8'h00; end
        end
        for (int c = 0; c < 100; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (d_ack[k] != 4'd0 && ack_cnt[k] < 5) begin
                    ack_cyc[k][ack_cnt[k]] = c;
                    ack_val[k][ack_cnt[k]] = d_q[k];
                    ack_cnt[k]++;
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rr_cnt%0d", k), 32'(ack_cnt[k]), 32'd5);
            for (int i = 0; i < 5; i++)
                chk($sformatf("rr_q%0d_%0d", k, i), 32'(ack_val[k][i]), 32'(rr_exp[i]));
            for (int i = 1; i < 5; i++)
                chk($sformatf("rr_gap%0d_%0d", k, i), 32'(ack_cyc[k][i] - ack_cyc[k][i-1]),
                    32'(hold_of[k] + 2));
        end
        req_s = 4'd0;
        repeat (20) @(negedge clk);

        // random traffic with occasional async reset pulses spanning an edge
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            if ($urandom_range(3) == 0) req_s = 4'($urandom);
            if ($urandom_range(3) == 0) data_s = $urandom;
            if (!rst && $urandom_range(199) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
